// File: rtl/wptr_full_ctrl_pkg.sv
// Shared widths, pointer type and Gray helper for the write-side FIFO controller.
package wptr_full_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned WPTR_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [WPTR_WIDTH-1:0] ptr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-domain bundle between the producer/memory side and the pointer controller.
import wptr_full_ctrl_pkg::*;

interface wptr_full_ctrl_if;
    logic  winc;
    ptr_t  rptr_sync;
    logic  wen;
    addr_t waddr;
    ptr_t  wptr;
    logic  wfull;
    logic  wafull;
    ptr_t  wlevel;
    logic  overflow;

    modport master (
        output winc, rptr_sync,
        input  wen, waddr, wptr, wfull, wafull, wlevel, overflow
    );

    modport slave (
        input  winc, rptr_sync,
        output wen, waddr, wptr, wfull, wafull, wlevel, overflow
    );
endinterface

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter; shared with the read-side empty controller.
module gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            bin[j] = ^(gray >> j);
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/full controller: Gray write pointer, full/almost-full, level, overflow.
import wptr_full_ctrl_pkg::*;

module wptr_full_ctrl #(
    parameter int unsigned AFULL_LEVEL = 12
) (
    input logic             clk,
    input logic             rst,
    wptr_full_ctrl_if.slave bus
);

    ptr_t wbin;
    ptr_t wptr_q;
    ptr_t wlevel_q;
    logic wfull_q;
    logic wafull_q;
    logic overflow_q;

    logic wen;
    ptr_t wbin_next;
    ptr_t wgray_next;
    ptr_t rptr_full_cmp;
    ptr_t rbin;
    ptr_t wlevel_next;
    logic wfull_next;
    logic wafull_next;

    gray2bin #(.WIDTH(WPTR_WIDTH)) u_gray2bin (
        .gray (bus.rptr_sync),
        .bin  (rbin)
    );

    // Registered wfull gates the strobe, so a write in the cycle the reader frees a slot is still dropped.
    assign wen         = bus.winc & ~wfull_q & ~rst;
    assign wbin_next   = wbin + ptr_t'(wen);
    assign wgray_next  = bin2gray(wbin_next);

    assign rptr_full_cmp = {~bus.rptr_sync[WPTR_WIDTH-1 -: 2], bus.rptr_sync[WPTR_WIDTH-3:0]};
    assign wfull_next    = (wgray_next == rptr_full_cmp);
    assign wlevel_next   = wbin_next - rbin;
    assign wafull_next   = (32'(wlevel_next) >= AFULL_LEVEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin       <= '0;
            wptr_q     <= '0;
            wfull_q    <= 1'b0;
            wafull_q   <= 1'b0;
            wlevel_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wbin     <= wbin_next;
            wptr_q   <= wgray_next;
            wfull_q  <= wfull_next;
            wafull_q <= wafull_next;
            wlevel_q <= wlevel_next;
            if (bus.winc && wfull_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.wen      = wen;
    assign bus.waddr    = wbin[ADDR_WIDTH-1:0];
    assign bus.wptr     = wptr_q;
    assign bus.wfull    = wfull_q;
    assign bus.wafull   = wafull_q;
    assign bus.wlevel   = wlevel_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: fill, overflow, drain, wrap, async reset, random traffic.
import wptr_full_ctrl_pkg::*;

module tb_wptr_full_ctrl;

    typedef struct {
        ptr_t wptr;
        logic wfull;
        logic wafull;
        ptr_t wlevel;
        logic overflow;
    } exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    exp_t sb[$];

    ptr_t m_wbin;
    logic m_full;
    logic m_ov;
    ptr_t prev_wptr;

    wptr_full_ctrl_if bus();

    wptr_full_ctrl #(.AFULL_LEVEL(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic ptr_t to_gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wbin    = '0;
        m_full    = 1'b0;
        m_ov      = 1'b0;
        prev_wptr = '0;
        sb.delete();
    endtask

    // Called with clk low; drives one cycle and scores the edge that consumes it.
    task automatic step(input logic w, input ptr_t rp);
        exp_t e;
        exp_t got;
        ptr_t nxt;
        ptr_t lvl;
        logic ew;
        bus.winc      = w;
        bus.rptr_sync = to_gray(rp);
        #1;
        ew = w & ~m_full;
        check_eq("wen", 32'(bus.wen), 32'(ew));
        check_eq("waddr", 32'(bus.waddr), 32'(m_wbin[ADDR_WIDTH-1:0]));
        check_eq("no_wr_full", 32'(bus.wen & bus.wfull), 32'd0);
        nxt        = m_wbin + ptr_t'(ew);
        lvl        = nxt - rp;
        e.wptr     = to_gray(nxt);
        e.wfull    = (lvl == 5'd16);
        e.wafull   = (lvl >= 5'd12);
        e.wlevel   = lvl;
        e.overflow = m_ov | (w & m_full);
        sb.push_back(e);
        m_wbin = nxt;
        m_full = e.wfull;
        m_ov   = e.overflow;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check_eq("wptr", 32'(bus.wptr), 32'(got.wptr));
            check_eq("wfull", 32'(bus.wfull), 32'(got.wfull));
            check_eq("wafull", 32'(bus.wafull), 32'(got.wafull));
            check_eq("wlevel", 32'(bus.wlevel), 32'(got.wlevel));
            check_eq("overflow", 32'(bus.overflow), 32'(got.overflow));
        end
        check_eq("wptr_hamming_le1", 32'($countones(bus.wptr ^ prev_wptr) <= 1), 32'd1);
        prev_wptr = bus.wptr;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wptr"}, 32'(bus.wptr), 32'd0);
        check_eq({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
        check_eq({tag, "_wen"}, 32'(bus.wen), 32'd0);
        check_eq({tag, "_wfull"}, 32'(bus.wfull), 32'd0);
        check_eq({tag, "_wafull"}, 32'(bus.wafull), 32'd0);
        check_eq({tag, "_wlevel"}, 32'(bus.wlevel), 32'd0);
        check_eq({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    endtask

    ptr_t m_rd;
    ptr_t rp_drv;
    ptr_t hist [3];

    initial begin
        bus.winc      = 1'b1;
        bus.rptr_sync = '0;
        model_reset();

        // Power-on reset with the clock not yet running.
        #1 rst = 1'b1;
        #2;
        check_all_zero("por");
        bus.winc = 1'b0;
        #2 rst = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);

        // Fill: 16 writes against an idle reader.
        for (int unsigned i = 1; i <= 16; i++) begin
            step(1'b1, 5'd0);
            if (i == 11) check_eq("afull_before_12", 32'(bus.wafull), 32'd0);
            if (i == 12) check_eq("afull_at_12", 32'(bus.wafull), 32'd1);
            if (i == 15) check_eq("full_before_16", 32'(bus.wfull), 32'd0);
        end
        check_eq("fill_wfull", 32'(bus.wfull), 32'd1);
        check_eq("fill_wlevel", 32'(bus.wlevel), 32'd16);
        check_eq("fill_wptr", 32'(bus.wptr), 32'b11000);

        // Overflow: write while full is dropped and the flag sticks.
        step(1'b1, 5'd0);
        check_eq("ovf_wptr_hold", 32'(bus.wptr), 32'b11000);
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);

        // Drain: reader advances to 4 then 5.
        step(1'b0, 5'd4);
        check_eq("drain4_wfull", 32'(bus.wfull), 32'd0);
        check_eq("drain4_wlevel", 32'(bus.wlevel), 32'd12);
        check_eq("drain4_wafull", 32'(bus.wafull), 32'd1);
        step(1'b0, 5'd5);
        check_eq("drain5_wlevel", 32'(bus.wlevel), 32'd11);
        check_eq("drain5_wafull", 32'(bus.wafull), 32'd0);

        // Wrap-around: reader catches up to 16, then 16 writes carry wbin back to 0.
        step(1'b0, 5'd16);
        check_eq("wrap_start_level", 32'(bus.wlevel), 32'd0);
        for (int unsigned i = 0; i < 16; i++) begin
            step(1'b1, 5'd16);
        end
        check_eq("wrap_wptr", 32'(bus.wptr), 32'd0);
        check_eq("wrap_wfull", 32'(bus.wfull), 32'd1);
        check_eq("wrap_waddr", 32'(bus.waddr), 32'd0);
        check_eq("wrap_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Mid-stream reset with the clock stopped: outputs must clear with no edge.
        step(1'b0, 5'd20);
        step(1'b1, 5'd20);
        step(1'b1, 5'd20);
        clk_en   = 1'b0;
        bus.winc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #10;
        bus.winc      = 1'b0;
        bus.rptr_sync = '0;
        rst           = 1'b0;
        model_reset();
        clk_en = 1'b1;

        // Random traffic with the read pointer lagging a model reader by 2-3 cycles.
        m_rd   = '0;
        rp_drv = '0;
        for (int unsigned k = 0; k < 3; k++) hist[k] = '0;
        for (int unsigned n = 0; n < 1000; n++) begin
            if (((m_wbin - m_rd) != 5'd0) && ($urandom_range(0, 1) == 1)) m_rd = m_rd + 5'd1;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = m_rd;
            if ($urandom_range(0, 3) != 0) rp_drv = hist[2];
            step($urandom_range(0, 2) != 0, rp_drv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
